// File: rtl/stage3_shift_sub_divider.sv
// Sequential restoring divider: one quotient bit per clock by trial shift-subtract.
// Optional debug outputs are enabled with the macro STAGE3_DIV_TRACE_EN.
module stage3_shift_sub_divider #(
  parameter int NUM_INPUTS     = 4,
  parameter int BIT_WIDTH      = 8,
  parameter int DIVIDEND_WIDTH = BIT_WIDTH + NUM_INPUTS - 1 + $clog2(NUM_INPUTS),
  parameter int DIVISOR_WIDTH  = BIT_WIDTH
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [DIVIDEND_WIDTH-1:0] dividend,
  input  logic [DIVISOR_WIDTH-1:0]  divisor,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [DIVIDEND_WIDTH-1:0] quotient,
  output logic [DIVISOR_WIDTH-1:0]  remainder,
  output logic                      div_zero
`ifdef STAGE3_DIV_TRACE_EN
  ,
  output logic [DIVISOR_WIDTH:0]          trace_rem,
  output logic [$clog2(DIVIDEND_WIDTH)-1:0] trace_cnt,
  output logic                            trace_step
`endif
);

  localparam int CNT_W = (DIVIDEND_WIDTH > 1) ? $clog2(DIVIDEND_WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t                    state_r;
  state_t                    next_state_s;
  logic [DIVIDEND_WIDTH-1:0] dvd_r;
  logic [DIVISOR_WIDTH-1:0]  dsr_r;
  logic [DIVISOR_WIDTH:0]    rem_r;
  logic [DIVIDEND_WIDTH-1:0] q_r;
  logic [CNT_W-1:0]          cnt_r;
  logic                      zero_r;

  logic [DIVISOR_WIDTH:0]    shifted_s;
  logic [DIVISOR_WIDTH:0]    diff_s;
  logic                      take_s;
  logic                      last_step_s;

  // Trial subtraction for the bit currently selected by the step counter.
  always_comb begin
    shifted_s   = {rem_r[DIVISOR_WIDTH-1:0], dvd_r[cnt_r]};
    diff_s      = shifted_s - {1'b0, dsr_r};
    take_s      = (shifted_s >= {1'b0, dsr_r});
    last_step_s = (cnt_r == {CNT_W{1'b0}});
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Next-state logic; a zero divisor spends a single cycle in CALC so its
  // result appears one edge after acceptance.
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      IDLE: begin
        if (in_valid) next_state_s = CALC;
        else          next_state_s = IDLE;
      end
      CALC: begin
        if (zero_r || last_step_s) next_state_s = DONE;
        else                       next_state_s = CALC;
      end
      DONE: begin
        if (out_ready) next_state_s = IDLE;
        else           next_state_s = DONE;
      end
      default: next_state_s = IDLE;
    endcase
  end

  // Handshake outputs decoded from the registered state.
  always_comb begin
    in_ready  = (state_r == IDLE);
    out_valid = (state_r == DONE);
`ifdef STAGE3_DIV_TRACE_EN
    trace_step = (state_r == CALC);
`endif
  end

  // Datapath: operand capture, per-step restore/subtract, result publication.
  always_ff @(posedge clk) begin
    if (rst) begin
      dvd_r     <= {DIVIDEND_WIDTH{1'b0}};
      dsr_r     <= {DIVISOR_WIDTH{1'b0}};
      rem_r     <= {(DIVISOR_WIDTH + 1){1'b0}};
      q_r       <= {DIVIDEND_WIDTH{1'b0}};
      cnt_r     <= {CNT_W{1'b0}};
      zero_r    <= 1'b0;
      quotient  <= {DIVIDEND_WIDTH{1'b0}};
      remainder <= {DIVISOR_WIDTH{1'b0}};
      div_zero  <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (in_valid) begin
            dvd_r  <= dividend;
            dsr_r  <= divisor;
            rem_r  <= {(DIVISOR_WIDTH + 1){1'b0}};
            q_r    <= {DIVIDEND_WIDTH{1'b0}};
            cnt_r  <= CNT_W'(DIVIDEND_WIDTH - 1);
            zero_r <= (divisor == {DIVISOR_WIDTH{1'b0}});
          end
        end
        CALC: begin
          if (zero_r) begin
            quotient  <= {DIVIDEND_WIDTH{1'b1}};
            remainder <= dvd_r[DIVISOR_WIDTH-1:0];
            div_zero  <= 1'b1;
          end else begin
            rem_r      <= take_s ? diff_s : shifted_s;
            q_r[cnt_r] <= take_s;
            if (last_step_s) begin
              quotient  <= {q_r[DIVIDEND_WIDTH-1:1], take_s};
              remainder <= take_s ? diff_s[DIVISOR_WIDTH-1:0] : shifted_s[DIVISOR_WIDTH-1:0];
              div_zero  <= 1'b0;
            end else begin
              cnt_r <= cnt_r - {{(CNT_W - 1){1'b0}}, 1'b1};
            end
          end
        end
        DONE: begin
          zero_r <= zero_r;
        end
        default: begin
          zero_r <= 1'b0;
        end
      endcase
    end
  end

`ifdef STAGE3_DIV_TRACE_EN
  assign trace_rem = rem_r;
  assign trace_cnt = cnt_r;
`endif

endmodule

// File: tb/tb_stage3_shift_sub_divider.sv
// Randomised and directed bench for stage3_shift_sub_divider with an arithmetic reference model.
module tb_stage3_shift_sub_divider;
  localparam int DW = 13;
  localparam int SW = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] dividend;
  logic [SW-1:0] divisor;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] quotient;
  logic [SW-1:0] remainder;
  logic          div_zero;
`ifdef STAGE3_DIV_TRACE_EN
  logic [SW:0]   trace_rem;
  logic [3:0]    trace_cnt;
  logic          trace_step;
`endif

  int vectors = 0;
  int errors  = 0;

  always #5 clk = ~clk;

  stage3_shift_sub_divider dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .dividend(dividend), .divisor(divisor), .out_valid(out_valid),
    .out_ready(out_ready), .quotient(quotient), .remainder(remainder),
    .div_zero(div_zero)
`ifdef STAGE3_DIV_TRACE_EN
    , .trace_rem(trace_rem), .trace_cnt(trace_cnt), .trace_step(trace_step)
`endif
  );

  // Reference: plain unsigned division, with the divide-by-zero convention.
  function automatic void ref_div(input int a, input int b, output int q, output int r,
                                  output int dz, output int lat);
    if (b == 0) begin
      q = 8191; r = a % 256; dz = 1; lat = 1;
    end else begin
      q = a / b; r = a % b; dz = 0; lat = DW;
    end
  endfunction

  task automatic send(input int a, input int b);
    int w = 0;
    while (!in_ready && w < 50) begin @(posedge clk); #1; w++; end
    in_valid = 1'b1; dividend = DW'(a); divisor = SW'(b);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_valid(output int lat);
    lat = 0;
    while (!out_valid && lat < 200) begin @(posedge clk); #1; lat++; end
  endtask

  task automatic pop();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; dividend = '0; divisor = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    vectors++;
    if ({in_ready, out_valid, quotient, remainder, div_zero} !== {1'b1, 1'b0, 13'd0, 8'd0, 1'b0}) begin
      errors++;
      $display("FAIL reset: rdy=%b vld=%b q=%0d r=%0d dz=%b, required 1 0 0 0 0",
               in_ready, out_valid, quotient, remainder, div_zero);
    end
  endtask

  task automatic test_directed();
    int ta[4] = '{100, 8191, 0, 5000};
    int tb[4] = '{7, 255, 1, 0};
    int q, r, dz, el, lat;
    for (int i = 0; i < 4; i++) begin
      ref_div(ta[i], tb[i], q, r, dz, el);
      send(ta[i], tb[i]);
      wait_valid(lat);
      vectors++;
      if (lat !== el || quotient !== DW'(q) || remainder !== SW'(r) || div_zero !== dz[0]) begin
        errors++;
        $display("FAIL directed %0d/%0d: lat=%0d q=%0d r=%0d dz=%b, required lat=%0d q=%0d r=%0d dz=%0d",
                 ta[i], tb[i], lat, quotient, remainder, div_zero, el, q, r, dz);
      end
      pop();
      vectors++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
        errors++;
        $display("FAIL directed_release: vld=%b rdy=%b, required 0 1", out_valid, in_ready);
      end
    end
  endtask

  task automatic test_backpressure();
    int lat;
    send(200, 9);
    wait_valid(lat);
    for (int i = 0; i < 20; i++) begin
      vectors++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || quotient !== 13'd22 || remainder !== 8'd2) begin
        errors++;
        $display("FAIL backpressure cycle %0d: vld=%b rdy=%b q=%0d r=%0d, required 1 0 22 2",
                 i, out_valid, in_ready, quotient, remainder);
      end
      in_valid = 1'b1; dividend = 13'd1; divisor = 8'd1;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    vectors++;
    if (in_ready !== 1'b0) begin
      errors++;
      $display("FAIL backpressure_no_comb_ready: rdy=%b, required 0", in_ready);
    end
    out_ready = 1'b1;
    #1;
    vectors++;
    if (in_ready !== 1'b0) begin
      errors++;
      $display("FAIL backpressure_comb_ready: rdy=%b, required 0", in_ready);
    end
    @(posedge clk); #1;
    out_ready = 1'b0;
    vectors++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL backpressure_release: vld=%b rdy=%b, required 0 1", out_valid, in_ready);
    end
  endtask

  task automatic test_reset_mid();
    int lat, seen = 0;
    send(1234, 10);
    repeat (5) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    vectors++;
    if ({in_ready, out_valid, quotient, remainder, div_zero} !== {1'b1, 1'b0, 13'd0, 8'd0, 1'b0}) begin
      errors++;
      $display("FAIL reset_mid: rdy=%b vld=%b q=%0d r=%0d dz=%b, required 1 0 0 0 0",
               in_ready, out_valid, quotient, remainder, div_zero);
    end
    for (int i = 0; i < 20; i++) begin
      if (out_valid) seen++;
      @(posedge clk); #1;
    end
    vectors++;
    if (seen !== 0) begin
      errors++;
      $display("FAIL reset_mid_abort: out_valid cycles=%0d, required 0", seen);
    end
    send(1234, 10);
    wait_valid(lat);
    vectors++;
    if (lat !== DW || quotient !== 13'd123 || remainder !== 8'd4) begin
      errors++;
      $display("FAIL reset_mid_rerun: lat=%0d q=%0d r=%0d, required 13 123 4", lat, quotient, remainder);
    end
    pop();
  endtask

  task automatic test_ignored();
    int lat, seen = 0;
    send(77, 3);
    repeat (3) @(posedge clk);
    #1;
    in_valid = 1'b1; dividend = 13'd50; divisor = 8'd5;
    vectors++;
    if (in_ready !== 1'b0) begin
      errors++;
      $display("FAIL ignored_ready: rdy=%b, required 0", in_ready);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    wait_valid(lat);
    vectors++;
    if (lat + 4 !== DW || quotient !== 13'd25 || remainder !== 8'd2) begin
      errors++;
      $display("FAIL ignored_result: lat=%0d q=%0d r=%0d, required 13 25 2", lat + 4, quotient, remainder);
    end
    pop();
    for (int i = 0; i < 20; i++) begin
      if (out_valid || !in_ready) seen++;
      @(posedge clk); #1;
    end
    vectors++;
    if (seen !== 0) begin
      errors++;
      $display("FAIL ignored_extra_job: busy cycles=%0d, required 0", seen);
    end
  endtask

  task automatic test_random();
    int a, b, q, r, dz, el, lat;
    for (int n = 0; n < 2000; n++) begin
      a = int'($urandom_range(0, 8191));
      b = ($urandom_range(0, 15) == 0) ? 0 : int'($urandom_range(1, 255));
      ref_div(a, b, q, r, dz, el);
      send(a, b);
      wait_valid(lat);
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #1;
      vectors++;
      if (lat !== el || quotient !== DW'(q) || remainder !== SW'(r) || div_zero !== dz[0] ||
          (dz == 0 && (int'(quotient) * b + int'(remainder) != a || int'(remainder) >= b))) begin
        errors++;
        $display("FAIL random %0d/%0d: lat=%0d q=%0d r=%0d dz=%b, required lat=%0d q=%0d r=%0d dz=%0d",
                 a, b, lat, quotient, remainder, div_zero, el, q, r, dz);
      end
      pop();
    end
  endtask

`ifdef STAGE3_DIV_TRACE_EN
  task automatic test_trace();
    int steps, bad, guard;
    for (int n = 0; n < 4; n++) begin
      steps = 0; bad = 0; guard = 0;
      send(int'($urandom_range(0, 8191)), int'($urandom_range(1, 255)));
      while (!out_valid && guard < 100) begin
        if (trace_step) begin
          if (int'(trace_cnt) != 12 - steps) bad++;
          steps++;
        end
        @(posedge clk); #1;
        guard++;
      end
      vectors++;
      if (steps !== 13 || bad !== 0) begin
        errors++;
        $display("FAIL trace: step cycles=%0d bad counts=%0d, required 13 0", steps, bad);
      end
      pop();
    end
  endtask
`endif

  initial begin
    test_reset();
    test_directed();
    test_backpressure();
    test_reset_mid();
    test_ignored();
    test_random();
`ifdef STAGE3_DIV_TRACE_EN
    test_trace();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
